// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side memory path: arbiter state encoding,
// requester port identifiers and the default bus widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_ARB_IDLE  = 2'd0,
    ST_ARB_ISSUE = 2'd1,
    ST_ARB_WAIT  = 2'd2,
    ST_ARB_DONE  = 2'd3
  } arb_state_e;

  localparam logic PORT_CPU  = 1'b0;
  localparam logic PORT_HOST = 1'b1;

  localparam int DEF_ADDR_BITS      = 16;
  localparam int DEF_DATA_BITS      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant selection; a tie goes to the port that did not
// win last time, and the history only moves when the grant is consumed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (advance && (grant != 2'b00)) begin
      last_grant_d = grant[1];
    end
  end

  // Starting at 1 lets port 0 win the very first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one SPI RAM controller between the CPU and the host loader port:
// one transaction at a time, round-robin on ties, watchdog on a stuck busy.
module spi_ram_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_BITS      = DEF_ADDR_BITS,
  parameter int DATA_BITS      = DEF_DATA_BITS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_i,
  input  logic                 we0_i,
  input  logic [ADDR_BITS-1:0] addr0_i,
  input  logic [DATA_BITS-1:0] wdata0_i,
  output logic                 done0_o,
  output logic [DATA_BITS-1:0] rdata0_o,
  input  logic                 req1_i,
  input  logic                 we1_i,
  input  logic [ADDR_BITS-1:0] addr1_i,
  input  logic [DATA_BITS-1:0] wdata1_i,
  output logic                 done1_o,
  output logic [DATA_BITS-1:0] rdata1_o,
  output logic                 err_o,
  output logic [ADDR_BITS-1:0] ram_addr_o,
  output logic [DATA_BITS-1:0] ram_wdata_o,
  output logic                 ram_start_read_o,
  output logic                 ram_start_write_o,
  input  logic [DATA_BITS-1:0] ram_rdata_i,
  input  logic                 ram_busy_i
);

  localparam int CNT_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  arb_state_e state_q, state_d;

  logic [1:0]           grant;
  logic                 grant_valid;
  logic                 advance;
  logic                 timeout_hit;

  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [DATA_BITS-1:0] rdata0_q, rdata0_d;
  logic [DATA_BITS-1:0] rdata1_q, rdata1_d;
  logic                 err_q, err_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_i, req0_i}),
    .advance (advance),
    .grant   (grant)
  );

  assign advance     = (state_q == ST_ARB_IDLE);
  assign grant_valid = (grant != 2'b00);
  assign timeout_hit = ram_busy_i && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB_IDLE:  if (grant_valid) state_d = ST_ARB_ISSUE;
      ST_ARB_ISSUE: state_d = ST_ARB_WAIT;
      ST_ARB_WAIT:  if (!ram_busy_i || timeout_hit) state_d = ST_ARB_DONE;
      ST_ARB_DONE:  state_d = ST_ARB_IDLE;
      default:      state_d = ST_ARB_IDLE;
    endcase
  end

  always_comb begin
    ram_start_read_o  = 1'b0;
    ram_start_write_o = 1'b0;
    done0_o           = 1'b0;
    done1_o           = 1'b0;
    case (state_q)
      ST_ARB_ISSUE: begin
        ram_start_read_o  = ~we_q;
        ram_start_write_o = we_q;
      end
      ST_ARB_DONE: begin
        done0_o = (owner_q == PORT_CPU);
        done1_o = (owner_q == PORT_HOST);
      end
      default: ;
    endcase
  end

  // Requester inputs are copied once at grant; later changes are ignored.
  always_comb begin
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_ARB_IDLE: begin
        if (grant_valid) begin
          owner_d = grant[1];
          we_d    = grant[1] ? we1_i    : we0_i;
          addr_d  = grant[1] ? addr1_i  : addr0_i;
          wdata_d = grant[1] ? wdata1_i : wdata0_i;
        end
      end
      ST_ARB_ISSUE: cnt_d = '0;
      ST_ARB_WAIT: begin
        if (!ram_busy_i) begin
          if (!we_q && (owner_q == PORT_CPU)) rdata0_d = ram_rdata_i;
          if (!we_q && (owner_q == PORT_HOST)) rdata1_d = ram_rdata_i;
        end else if (timeout_hit) begin
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_BITS'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q  <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ram_addr_o  = addr_q;
  assign ram_wdata_o = wdata_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign err_o       = err_q;

endmodule
